// File: rtl/serial_subtractor_8bit.sv
// Bit-serial 8-bit subtractor d = a - b, LSB first, with one borrow flip-flop.
// Reports borrow, zero and signed-overflow flags under a start/ready/done handshake.
module serial_subtractor_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] d,
  output logic       borrow,
  output logic       zero,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  // Handshake: start is taken on a rising edge where start=1 and ready=1.
  // done is a one-cycle pulse; d and the flags stay valid until the next done.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] areg_q, breg_q, res_q;
  logic [2:0] cnt_q;
  logic       br_q;
  logic       a7_q, b7_q;
  logic [7:0] d_q;
  logic       borrow_q, zero_q, ovf_q;

  logic       a0, b0, diff_bit, br_d;
  logic [7:0] res_d;

  assign a0       = areg_q[0];
  assign b0       = breg_q[0];
  assign diff_bit = a0 ^ b0 ^ br_q;
  assign br_d     = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign res_d    = {diff_bit, res_q[7:1]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == 3'd7) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_IDLE:  ready = 1'b1;
      S_SHIFT: busy  = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      areg_q   <= 8'h00;
      breg_q   <= 8'h00;
      res_q    <= 8'h00;
      cnt_q    <= 3'd0;
      br_q     <= 1'b0;
      a7_q     <= 1'b0;
      b7_q     <= 1'b0;
      d_q      <= 8'h00;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            areg_q <= a;
            breg_q <= b;
            br_q   <= 1'b0;
            cnt_q  <= 3'd0;
            a7_q   <= a[7];
            b7_q   <= b[7];
          end
        end
        S_SHIFT: begin
          areg_q <= {1'b0, areg_q[7:1]};
          breg_q <= {1'b0, breg_q[7:1]};
          res_q  <= res_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + 3'd1;
          // Last bit: publish the result on the same edge that enters DONE.
          if (cnt_q == 3'd7) begin
            d_q      <= res_d;
            borrow_q <= br_d;
            zero_q   <= (res_d == 8'h00);
            ovf_q    <= (a7_q != b7_q) && (res_d[7] != a7_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign d         = d_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed bench for serial_subtractor_8bit with an expected-result queue.
module tb_serial_subtractor_8bit;

  logic       clk, rst, start;
  logic [7:0] a, b;
  logic       ready, busy, done;
  logic [7:0] d;
  logic       borrow, zero, overflow;
  logic [1:0] dbg_state;

  logic [10:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc1, acc2;

  serial_subtractor_8bit dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .d(d),
    .borrow(borrow), .zero(zero), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb);
    logic [7:0] md;
    md = ma - mb;
    return {md, (ma < mb), (md == 8'h00), ((ma[7] != mb[7]) && (md[7] != ma[7]))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one request; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input bit keep);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("issue_ready", {31'd0, ready}, 32'd1);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(ia, ib));
    if (!keep) start = 1'b0;
  endtask

  // Call 1 time unit after the accepting edge; checks busy length, latency, result.
  task automatic wait_result(input string tag);
    int n, busy_n;
    logic [10:0] e;
    n = 0; busy_n = 0;
    while (n < 30) begin
      @(negedge clk); n++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) break;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_latency"}, n, 32'd9);
    chk({tag, "_busy_cycles"}, busy_n, 32'd8);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_result"}, {21'd0, d, borrow, zero, overflow}, {21'd0, e});
    end
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b1; a = 8'h35; b = 8'h12;

    // Reset with start held high: nothing may start.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_outputs", {21'd0, d, borrow, zero, overflow}, 32'd0);
    @(posedge clk); #1;
    chk("rst_idle_after", {31'd0, busy}, 32'd0);

    issue(8'h35, 8'h12, 1'b0);
    a = 8'hAA; b = 8'h55;
    wait_result("sub_35_12");
    chk("sub_35_12_d", {24'd0, d}, 32'h23);

    issue(8'h00, 8'h01, 1'b0);
    wait_result("sub_00_01");
    chk("sub_00_01_d", {24'd0, d}, 32'hFF);

    issue(8'h7F, 8'hFF, 1'b0);
    wait_result("sub_7f_ff");
    chk("sub_7f_ff_flags", {29'd0, d[7], borrow, overflow}, 32'h7);

    issue(8'h80, 8'h01, 1'b0);
    wait_result("sub_80_01");
    chk("sub_80_01_flags", {22'd0, d, borrow, overflow}, {22'd0, 8'h7F, 2'b01});

    // Back-to-back with start held; inputs scrambled during SHIFT.
    issue(8'h5A, 8'h5A, 1'b1);
    acc1 = cyc;
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    wait_result("sub_5a_5a");
    chk("sub_5a_5a_zero", {23'd0, d, zero}, 32'h1);
    a = 8'h10; b = 8'h03;
    @(posedge clk); #1;
    chk("b2b_ready_after_done", {31'd0, ready}, 32'd1);
    chk("b2b_d_hold", {24'd0, d}, 32'h00);
    @(posedge clk); #1;
    acc2 = cyc;
    exp_q.push_back(model(8'h10, 8'h03));
    start = 1'b0;
    chk("b2b_accept_spacing", acc2 - acc1, 32'd10);
    chk("b2b_busy_after_accept", {31'd0, busy}, 32'd1);
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    chk("b2b_d_hold_in_shift", {23'd0, d, zero}, 32'h1);
    wait_result("sub_10_03");

    // Reset during the 4th SHIFT cycle discards the operation.
    issue(8'h35, 8'h12, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_outputs", {21'd0, d, borrow, zero, overflow}, 32'd0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("midrst_no_done", pulses, 32'd0);
    #1;
    issue(8'h10, 8'h01, 1'b0);
    wait_result("sub_10_01");
    chk("sub_10_01_d", {24'd0, d}, 32'h0F);

    // Randomised operands through the same scoreboard path.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      wait_result("rand_op");
    end

    chk("queue_empty_at_end", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor_8bit.md
# serial_subtractor_8bit

Bit-serial 8-bit subtractor computing d = a − b one bit per clock, least-significant bit first, with a single borrow flip-flop. It is the inverse-operation counterpart to the ripple-carry 8-bit adder in the ALU datapath. It trades latency for area and reports borrow, zero and signed-overflow flags alongside the difference. Operation is governed by a start/ready/done handshake so the ALU sequencer can issue one subtraction at a time.

## Interface
- No parameters; width fixed at 8 bits.
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a subtraction; accepted only when ready=1.
- a  in  8  minuend, unsigned or two's complement; sampled on the accepting edge only.
- b  in  8  subtrahend; sampled on the accepting edge only.
- ready  out  1  high in IDLE; start is accepted on this cycle's edge.
- busy  out  1  high while bits are being processed (SHIFT).
- done  out  1  one-cycle pulse; result and flags are valid from this cycle onward.
- d  out  8  difference a − b mod 256; held until the next result.
- borrow  out  1  1 iff a < b as unsigned values.
- zero  out  1  1 iff d == 0x00.
- overflow  out  1  signed overflow: (a[7] != b[7]) && (d[7] != a[7]).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1, busy=0, done=0.
  - On start=1, load a and b into shift registers, clear the borrow flip-flop, clear the 3-bit bit counter, then go to SHIFT.
  - start=0 keeps the state in IDLE.
- SHIFT: busy=1, ready=0. Each cycle, using a0 = areg[0] and b0 = breg[0]:
  - diff bit = a0 ^ b0 ^ br.
  - next br = (~a0 & b0) | (~(a0 ^ b0) & br).
  - The diff bit shifts into the result shift register from the MSB side.
  - areg and breg shift right by one.
  - The counter increments.
  - When the counter is 7, the transition goes to DONE on that edge. That same edge loads d, borrow (the final br), zero, and overflow (computed from the latched operand sign bits and the final d[7]).
- DONE: done=1, ready=0, busy=0; unconditionally go to IDLE on the next edge.
- start is ignored in SHIFT and DONE; it has no queueing effect.
- Holding start high continuously starts a new operation on every IDLE cycle.
- Changes on a and b after the accepting edge have no effect on the result in flight.
- d and the flags change only on entry to DONE or on reset. Between operations they hold the last result.
- Reset, from any state including mid-SHIFT:
  - State returns to IDLE on the next edge.
  - The operation in flight is discarded; no done pulse is generated.
  - d=0x00, borrow=0, zero=0, overflow=0, done=0, busy=0, ready=1.
  - Internal shift registers, counter and borrow flip-flop clear.
- Reset has priority over start when both are asserted on the same edge.

## Timing
- The accepting edge is E, where start=1 and ready=1 are sampled.
- SHIFT occupies the 8 cycles following E. The edge E+8 loads the results and enters DONE.
- done is high for exactly one cycle, between E+8 and E+9. ready returns high after E+9.
- Latency is 9 cycles from the accepting edge to the done pulse. Throughput is one operation per 10 cycles when start is held high.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Test plan
- Reset behaviour: assert rst for 2 cycles with start=1 → ready=1, busy=0, done=0, d=0x00, and all flags 0; no operation starts while rst=1.
- Basic subtraction: a=0x35, b=0x12, start pulsed one cycle:
  - busy is high for exactly 8 cycles.
  - done pulses 9 cycles after acceptance.
  - d=0x23, borrow=0, zero=0, overflow=0.
- Borrow and wrap-around:
  - 0x00 − 0x01 → d=0xFF, borrow=1, overflow=0.
  - 0x7F − 0xFF → d=0x80, borrow=1, overflow=1.
- Signed overflow with no borrow: 0x80 − 0x01 → d=0x7F, borrow=0, overflow=1.
- Zero result and back-to-back operation:
  - 0x5A − 0x5A → d=0x00, zero=1.
  - With start held high, the next accept occurs exactly 10 cycles after the first.
  - Changing a/b during SHIFT does not alter the result; d holds between the two done pulses.
- Reset mid-operation: assert rst during the 4th SHIFT cycle of 0x35 − 0x12 → IDLE next cycle, no done pulse, d=0x00. A new 0x10 − 0x01 afterwards produces d=0x0F with normal 9-cycle latency.
